ccd_frame_writer: RTL and testbench

- Camera-side producer for the CCD input FIFO of the SRAM frame store. Captures the camera's frame/line/pixel-valid RGB stream on CCD_FIFO_WRCLK and crops it to a DISPLAY-sized window.
- Writes 30-bit {R,G,B} words into the FIFO while honouring CCD_FIFO_FULL.
- Guarantees exactly W*H FIFO writes per accepted frame. Pixels lost to overflow or a short frame are replaced by black padding, so the controller's wrapping store address stays frame-aligned.

---
 rtl/ccd_frame_writer.sv | 212 +++++++++++++++++++++
 tb/tb_ccd_frame_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ccd_frame_writer.sv
// ---------------------------------------------------------------------------
// ccd_frame_writer
//
// Camera-side producer for the CCD input FIFO of the SRAM frame store.
// Samples the camera frame/line/pixel-valid RGB stream, crops it to a
// WIDTH x HEIGHT window starting at (X_START, Y_START), and pushes 30-bit
// {R,G,B} words into the FIFO.
//
// Every accepted frame produces exactly WIDTH*HEIGHT FIFO writes. Pixels
// lost to a full FIFO, or never delivered because the frame ended early,
// are made up with black (30'h0) words after the frame ends. This keeps
// the downstream store address frame-aligned.
//
// Ports
//   CCD_FIFO_WRCLK  capture clock, all logic on its rising edge
//   RESET_N         asynchronous active-low reset
//   iFVAL/iLVAL/iDVAL  camera frame / line / pixel valid
//   iRED/iGREEN/iBLUE  10-bit colour components
//   iENABLE         capture enable, looked at only on an iFVAL rising edge
//   iCLR_STATUS     clears oOVERFLOW (a same-cycle new drop wins)
//   CCD_FIFO_FULL   FIFO full, checked in the cycle the pixel is sampled
//   CCD_FIFO_IN     FIFO write data {R[29:20],G[19:10],B[9:0]}
//   CCD_FIFO_WE     FIFO write strobe, one word per cycle high
//   oFRAME_CNT      completed frames, wraps at 2^16
//   oDROP_CNT       drops plus pad words of the last completed frame
//   oOVERFLOW       sticky: a pixel was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ccd_frame_writer #(
    parameter int WIDTH   = 800,
    parameter int HEIGHT  = 480,
    parameter int X_START = 0,
    parameter int Y_START = 0
) (
    input  logic        CCD_FIFO_WRCLK,
    input  logic        RESET_N,
    input  logic        iFVAL,
    input  logic        iLVAL,
    input  logic        iDVAL,
    input  logic [9:0]  iRED,
    input  logic [9:0]  iGREEN,
    input  logic [9:0]  iBLUE,
    input  logic        iENABLE,
    input  logic        iCLR_STATUS,
    input  logic        CCD_FIFO_FULL,
    output logic [29:0] CCD_FIFO_IN,
    output logic        CCD_FIFO_WE,
    output logic [15:0] oFRAME_CNT,
    output logic [19:0] oDROP_CNT,
    output logic        oOVERFLOW
);

    localparam logic [19:0] FRAME_WORDS = 20'(WIDTH * HEIGHT);
    localparam logic [15:0] XS = 16'(X_START);
    localparam logic [15:0] XW = 16'(WIDTH);
    localparam logic [15:0] YS = 16'(Y_START);
    localparam logic [15:0] YH = 16'(HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PAD     = 2'd2
    } state_t;

    state_t      state_q;
    logic        fval_q;
    logic        lval_q;
    logic [15:0] x_q;
    logic [15:0] y_q;
    logic [19:0] wr_cnt_q;
    logic [19:0] drop_q;
    logic [29:0] data_q;
    logic        we_q;
    logic [15:0] frame_cnt_q;
    logic [19:0] drop_cnt_q;
    logic        ovf_q;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic        fval_rise;
    logic        fval_fall;
    logic        lval_fall;
    logic        pix;
    logic [16:0] dx;
    logic [16:0] dy;
    logic        in_win;
    logic        room;
    logic        accept;
    logic        ovf_set;
    logic        pad_last;

    assign fval_rise = iFVAL & ~fval_q;
    assign fval_fall = ~iFVAL & fval_q;
    assign lval_fall = ~iLVAL & lval_q;
    assign pix       = iFVAL & iLVAL & iDVAL;

    // Window test as an offset subtraction: the borrow bit says "before the
    // start", the low bits are compared against the window size. This avoids
    // X_START+WIDTH overflow and a degenerate compare when the start is 0.
    assign dx     = {1'b0, x_q} - {1'b0, XS};
    assign dy     = {1'b0, y_q} - {1'b0, YS};
    assign in_win = ~dx[16] & (dx[15:0] < XW) & ~dy[16] & (dy[15:0] < YH);

    assign room     = (wr_cnt_q < FRAME_WORDS);
    assign accept   = (state_q == S_CAPTURE) & pix & in_win & room;
    assign ovf_set  = accept & CCD_FIFO_FULL;
    assign pad_last = (wr_cnt_q == FRAME_WORDS - 20'd1);

    // ------------------------------------------------------------------
    // Capture FSM and all registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            wr_cnt_q    <= '0;
            drop_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            fval_q <= iFVAL;
            lval_q <= iLVAL;
            we_q   <= 1'b0;

            // Sticky overflow; a new drop beats a simultaneous clear.
            if (ovf_set)
                ovf_q <= 1'b1;
            else if (iCLR_STATUS)
                ovf_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // A frame that starts while disabled is skipped whole.
                    if (fval_rise && iENABLE) begin
                        state_q  <= S_CAPTURE;
                        x_q      <= '0;
                        y_q      <= '0;
                        wr_cnt_q <= '0;
                        drop_q   <= '0;
                    end
                end

                S_CAPTURE: begin
                    // Counters saturate so an over-long line or frame can
                    // never wrap back into the window.
                    if (pix) begin
                        if (x_q != 16'hFFFF)
                            x_q <= x_q + 16'd1;
                    end else if (lval_fall) begin
                        x_q <= '0;
                        // x is non-zero exactly when the line held a pixel.
                        if (x_q != 16'd0 && y_q != 16'hFFFF)
                            y_q <= y_q + 16'd1;
                    end

                    if (accept) begin
                        if (!CCD_FIFO_FULL) begin
                            we_q     <= 1'b1;
                            data_q   <= {iRED, iGREEN, iBLUE};
                            wr_cnt_q <= wr_cnt_q + 20'd1;
                        end else begin
                            drop_q   <= drop_q + 20'd1;
                        end
                    end

                    // pix needs iFVAL high, so it never coincides with the
                    // falling edge and the counts above are already final.
                    if (fval_fall) begin
                        if (wr_cnt_q == FRAME_WORDS) begin
                            state_q     <= S_IDLE;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            drop_cnt_q  <= drop_q;
                        end else begin
                            state_q     <= S_PAD;
                        end
                    end
                end

                S_PAD: begin
                    // Camera inputs are ignored here; a frame start seen in
                    // this state is lost and IDLE waits for the next one.
                    if (!CCD_FIFO_FULL) begin
                        we_q     <= 1'b1;
                        data_q   <= '0;
                        wr_cnt_q <= wr_cnt_q + 20'd1;
                        drop_q   <= drop_q + 20'd1;
                        if (pad_last) begin
                            state_q     <= S_IDLE;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            drop_cnt_q  <= drop_q + 20'd1;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign CCD_FIFO_IN = data_q;
    assign CCD_FIFO_WE = we_q;
    assign oFRAME_CNT  = frame_cnt_q;
    assign oDROP_CNT   = drop_cnt_q;
    assign oOVERFLOW   = ovf_q;

endmodule

// File: tb/tb_ccd_frame_writer.sv
// ---------------------------------------------------------------------------
// tb_ccd_frame_writer
//
// Directed bench for ccd_frame_writer with a 4x3 window at offset (1,1).
// A table of whole-frame scenarios is driven through one frame task that
// checks every camera cycle (write strobe and data one cycle after the
// sample); per-frame totals are checked afterwards. Hand-written sequences
// cover the PAD stall, reset in the middle of a capture and reset state.
// ---------------------------------------------------------------------------
module tb_ccd_frame_writer;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int XS  = 1;
    localparam int YS  = 1;
    localparam int PPL = 6;   // camera pixels per line

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        fval  = 1'b0;
    logic        lval  = 1'b0;
    logic        dval  = 1'b0;
    logic [9:0]  r     = '0;
    logic [9:0]  g     = '0;
    logic [9:0]  b     = '0;
    logic        en    = 1'b0;
    logic        clr   = 1'b0;
    logic        full  = 1'b0;
    logic [29:0] fifo_in;
    logic        we;
    logic [15:0] frame_cnt;
    logic [19:0] drop_cnt;
    logic        ovf;

    ccd_frame_writer #(.WIDTH(W), .HEIGHT(H), .X_START(XS), .Y_START(YS)) dut (
        .CCD_FIFO_WRCLK (clk),
        .RESET_N        (rst_n),
        .iFVAL          (fval),
        .iLVAL          (lval),
        .iDVAL          (dval),
        .iRED           (r),
        .iGREEN         (g),
        .iBLUE          (b),
        .iENABLE        (en),
        .iCLR_STATUS    (clr),
        .CCD_FIFO_FULL  (full),
        .CCD_FIFO_IN    (fifo_in),
        .CCD_FIFO_WE    (we),
        .oFRAME_CNT     (frame_cnt),
        .oDROP_CNT      (drop_cnt),
        .oOVERFLOW      (ovf)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Running write totals, sampled on the falling edge.
    int wr_total   = 0;
    int zero_total = 0;
    always @(negedge clk) begin
        if (we) begin
            wr_total++;
            if (fifo_in == 30'h0) zero_total++;
        end
    end

    // Camera pixel values are never zero, so a zero word is always a pad.
    function automatic logic [29:0] pixval(input int x, input int y);
        return {10'(100 + y), 10'(200 + x), 10'(300 + 16 * y + x)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Inputs change here; the DUT samples them at the next rising edge and
    // results are looked at just after the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Drives one camera frame of nlines x PPL pixels. full_at / clr_at are
    // the in-window pixel indices that see FULL / CLR_STATUS (-1 = none).
    // Ends right after the iFVAL falling edge has been sampled.
    task automatic run_capture(input bit e, input int nlines, input int full_at, input int clr_at);
        int          k;
        bit          win;
        bit          xw;
        logic [29:0] pv;
        k = 0;
        en = e; fval = 1'b1;
        step();
        chk("rise_we", we, 0);
        for (int ln = 0; ln < nlines; ln++) begin
            lval = 1'b1;
            for (int px = 0; px < PPL; px++) begin
                win = (px >= XS) && (px < XS + W) && (ln >= YS) && (ln < YS + H);
                pv  = pixval(px, ln);
                {r, g, b} = pv;
                dval = 1'b1;
                full = win && (k == full_at);
                clr  = win && (k == clr_at);
                step();
                xw = e && win && !full;
                chk("cap_we", we, 32'(xw));
                if (xw) chk("cap_data", fifo_in, pv);
                if (win && k == clr_at) chk("set_beats_clr", ovf, 1);
                if (win) k++;
            end
            dval = 1'b0; lval = 1'b0; full = 1'b0; clr = 1'b0;
            step();
            chk("eol_we", we, 0);
            step();
        end
        fval = 1'b0;
        step();
        chk("eof_we", we, 0);
    endtask

    typedef struct {
        string name;
        bit    en;
        int    nlines;
        int    full_at;
        int    clr_at;
        int    exp_cam;
        int    exp_zero;
        int    exp_finc;
        int    exp_drop;
        bit    exp_ovf;
        bit    clr_after;
    } vec_t;

    vec_t tbl[6];
    int   exp_frames;
    int   w0;
    int   z0;
    int   k;

    initial begin
        // A dropped pixel counts once as a drop and once more as the pad
        // word that replaces it, hence drop 2 for a single overflow.
        tbl[0] = '{"clean",      1'b1, 5, -1, -1, 12, 0, 1, 0, 1'b0, 1'b1};
        tbl[1] = '{"overflow",   1'b1, 5,  2, -1, 11, 1, 1, 2, 1'b1, 1'b0};
        tbl[2] = '{"set_vs_clr", 1'b1, 5,  3,  3, 11, 1, 1, 2, 1'b1, 1'b1};
        tbl[3] = '{"short",      1'b1, 2, -1, -1,  4, 8, 1, 8, 1'b0, 1'b1};
        tbl[4] = '{"disabled",   1'b0, 5, -1, -1,  0, 0, 0, 8, 1'b0, 1'b1};
        tbl[5] = '{"reenabled",  1'b1, 5, -1, -1, 12, 0, 1, 0, 1'b0, 1'b1};
        exp_frames = 0;

        // Reset state
        step();
        step();
        chk("rst_we",    we, 0);
        chk("rst_data",  fifo_in, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_drop",  drop_cnt, 0);
        chk("rst_ovf",   ovf, 0);
        rst_n = 1'b1;
        step();

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            w0 = wr_total;
            z0 = zero_total;
            run_capture(tbl[i].en, tbl[i].nlines, tbl[i].full_at, tbl[i].clr_at);
            repeat (16) step();
            exp_frames += tbl[i].exp_finc;
            chk({tbl[i].name, "_cam"},   32'((wr_total - w0) - (zero_total - z0)), 32'(tbl[i].exp_cam));
            chk({tbl[i].name, "_zero"},  32'(zero_total - z0), 32'(tbl[i].exp_zero));
            chk({tbl[i].name, "_frame"}, frame_cnt, 32'(exp_frames));
            chk({tbl[i].name, "_drop"},  drop_cnt, 32'(tbl[i].exp_drop));
            chk({tbl[i].name, "_ovf"},   ovf, 32'(tbl[i].exp_ovf));
            if (tbl[i].clr_after) begin
                clr = 1'b1;
                step();
                clr = 1'b0;
                chk({tbl[i].name, "_clr"}, ovf, 0);
            end
        end

        // Short frame with FULL held for 3 cycles while padding
        w0 = wr_total;
        run_capture(1'b1, 2, -1, -1);
        repeat (2) begin step(); chk("pad_we", we, 1); chk("pad_data", fifo_in, 0); end
        full = 1'b1;
        repeat (3) begin step(); chk("stall_we", we, 0); end
        full = 1'b0;
        repeat (6) begin step(); chk("pad_we", we, 1); chk("pad_data", fifo_in, 0); end
        step();
        chk("pad_done_we", we, 0);
        exp_frames++;
        chk("stall_total", 32'(wr_total - w0), 12);
        chk("stall_frame", frame_cnt, 32'(exp_frames));
        chk("stall_drop",  drop_cnt, 8);

        // Reset in the middle of a capture, right after the 5th write
        w0 = wr_total;
        k  = 0;
        en = 1'b1; fval = 1'b1;
        step();
        for (int ln = 0; ln < 5 && k < 5; ln++) begin
            lval = 1'b1;
            for (int px = 0; px < PPL && k < 5; px++) begin
                {r, g, b} = pixval(px, ln);
                dval = 1'b1;
                step();
                if ((px >= XS) && (px < XS + W) && (ln >= YS) && (ln < YS + H)) k++;
            end
            if (k < 5) begin
                dval = 1'b0; lval = 1'b0;
                step();
                step();
            end
        end
        chk("pre_rst_writes", 32'(wr_total - w0), 5);
        chk("pre_rst_we", we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_we",    we, 0);
        chk("async_data",  fifo_in, 0);
        chk("async_frame", frame_cnt, 0);
        chk("async_drop",  drop_cnt, 0);
        chk("async_ovf",   ovf, 0);
        fval = 1'b0; lval = 1'b0; dval = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        w0 = wr_total;
        z0 = zero_total;
        run_capture(1'b1, 5, -1, -1);
        repeat (16) step();
        chk("post_rst_writes", 32'(wr_total - w0), 12);
        chk("post_rst_zero",   32'(zero_total - z0), 0);
        chk("post_rst_frame",  frame_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
